// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM states and counter sizing.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned wide);
    return $clog2(wide);
  endfunction

endpackage

// File: rtl/booth_encoder.sv
// Radix-2 Booth recoding: per-bit digit magnitude (val) and sign, with op2[-1] = 0.
module booth_encoder #(
  parameter int unsigned WIDE = 8
) (
  input  logic [WIDE-1:0] op2,
  output logic [WIDE-1:0] val,
  output logic [WIDE-1:0] sign
);

  always_comb begin
    val  = op2 ^ {op2[WIDE-2:0], 1'b0};
    sign = op2;
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one signed partial product per cycle into a
// 2*WIDE-bit accumulator, with valid/ready handshakes on operand and result sides.
module booth_mult_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDE-1:0]   op1,
  input  logic [WIDE-1:0]   op2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*WIDE-1:0] product
);

  localparam int unsigned CW = cnt_w(WIDE);
  localparam int unsigned PW = 2 * WIDE;

  state_e          state_q, state_d;
  logic [PW-1:0]   a_q, a_d;
  logic [WIDE-1:0] op2_q, op2_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  logic [WIDE-1:0] enc_val, enc_sign;
  logic            dig_val, dig_sign;
  logic [PW-1:0]   shifted, addend, sum;

  booth_encoder #(.WIDE(WIDE)) u_enc (
    .op2  (op2_q),
    .val  (enc_val),
    .sign (enc_sign)
  );

  // A is already sign-extended, so subtracting via invert plus carry-in is exact
  // even for the most negative operand.
  always_comb begin
    dig_val  = enc_val[cnt_q];
    dig_sign = enc_sign[cnt_q];
    shifted  = a_q << cnt_q;
    addend   = shifted ^ {PW{dig_sign}};
    sum      = acc_q + addend + {{(PW-1){1'b0}}, dig_sign};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    op2_d   = op2_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = {{WIDE{op1[WIDE-1]}}, op1};
          op2_d   = op2;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (dig_val) begin
          acc_d = sum;
        end
        if (cnt_q == CW'(WIDE - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      op2_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      op2_q       <= op2_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign product   = acc_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq (WIDE=8): directed table, corner sequences, random traffic.
module tb_booth_mult_seq;

  localparam int unsigned W = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    op1;
  logic [W-1:0]    op2;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  product;

  int errors = 0;
  int checks = 0;

  booth_mult_seq #(.WIDE(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb, p;
    sa = $signed(a);
    sb = $signed(b);
    p  = sa * sb;
    return p[2*W-1:0];
  endfunction

  // Offer a pair, scramble the inputs afterwards, and wait (bounded) for out_valid.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [2*W-1:0] p, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    op1 = a;
    op2 = b;
    step();
    in_valid = 1'b0;
    op1 = W'($urandom);
    op2 = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
      op1 = W'($urandom);
      op2 = W'($urandom);
    end
    p = product;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [2*W-1:0] p, held;
    int lat;
    bit stale;

    vecs[0] = '{a: 8'd3,   b: 8'd5,   exp: 16'h000F};
    vecs[1] = '{a: 8'hFF,  b: 8'd127, exp: 16'hFF81};
    vecs[2] = '{a: 8'd127, b: 8'hFF,  exp: 16'hFF81};
    vecs[3] = '{a: 8'd0,   b: 8'h80,  exp: 16'h0000};
    vecs[4] = '{a: 8'h80,  b: 8'h80,  exp: 16'h4000};
    vecs[5] = '{a: 8'h80,  b: 8'd127, exp: 16'hC080};
    vecs[6] = '{a: 8'd127, b: 8'd127, exp: 16'h3F01};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op1 = '0;
    op2 = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_product", {16'd0, product}, 32'd0);

    // Directed table; out_valid must appear WIDE edges after the accepting edge.
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, p, lat);
      chk($sformatf("vec%0d_product", i), {16'd0, p}, {16'd0, vecs[i].exp});
      chk($sformatf("vec%0d_latency", i), lat, W);
      release_result();
      chk($sformatf("vec%0d_idle", i), {31'd0, in_ready}, 32'd1);
    end

    // Backpressure: hold out_ready low, also offer in_valid which must be ignored.
    do_op(8'hF3, 8'h27, p, lat);
    chk("bp_product", {16'd0, p}, {16'd0, ref_mul(8'hF3, 8'h27)});
    held = product;
    stale = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (product !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stale = 1'b1;
    end
    in_valid = 1'b0;
    chk("bp_stable", {31'd0, stale}, 32'd0);
    release_result();
    chk("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
    do_op(8'h11, 8'hEE, p, lat);
    chk("bp_next_product", {16'd0, p}, {16'd0, ref_mul(8'h11, 8'hEE)});
    release_result();

    // Reset while cnt=4: operation is discarded and never produces out_valid.
    in_valid = 1'b1;
    op1 = 8'h55;
    op2 = 8'h6B;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_product", {16'd0, product}, 32'd0);
    stale = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    chk("abort_no_stale", {31'd0, stale}, 32'd0);

    // Reset coinciding with a handshake: operands are not accepted.
    rst = 1'b1;
    in_valid = 1'b1;
    op1 = 8'h7F;
    op2 = 8'h7F;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    step();
    chk("rst_hs_in_ready", {31'd0, in_ready}, 32'd1);
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stale = 1'b1;
    end
    chk("rst_hs_not_accepted", {31'd0, stale}, 32'd0);

    // Random traffic with idle gaps and result backpressure.
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] a, b;
      int gap;
      a = W'($urandom);
      b = W'($urandom);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
      do_op(a, b, p, lat);
      chk($sformatf("rand%0d_product a=%0h b=%0h", i, a, b), {16'd0, p}, {16'd0, ref_mul(a, b)});
      chk($sformatf("rand%0d_latency", i), lat, W);
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) step();
      chk($sformatf("rand%0d_held", i), {16'd0, product}, {16'd0, ref_mul(a, b)});
      release_result();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
